// File: rtl/pll_pkg.sv
// Shared encodings for the PLL profile sequencer.
// Command opcodes, CTRL sub-codes, chunk width and FSM states.
package pll_pkg;

    localparam logic [1:0] OP_SEQ   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CTRL  = 2'b11;

    localparam logic [1:0] CTRL_SELECT   = 2'b00;
    localparam logic [1:0] CTRL_SET_LAST = 2'b01;
    localparam logic [1:0] CTRL_STOP     = 2'b10;
    localparam logic [1:0] CTRL_STATIC   = 2'b11;

    localparam int CHUNK_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STATIC  = 2'd1,
        ST_SWEEP   = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

endpackage

// File: rtl/pll_profile_bank.sv
// FCW profile register file: one commit port, two async read ports.
// Port a feeds the DSM path, port b feeds readback and STATIC loads.
module pll_profile_bank #(
    parameter int NUM_PROFILES = 4,
    parameter int FCW_WIDTH    = 43,
    parameter int PADDR        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [PADDR-1:0]     waddr,
    input  logic [FCW_WIDTH-1:0] wdata,
    input  logic [PADDR-1:0]     addr_a,
    output logic [FCW_WIDTH-1:0] data_a,
    input  logic [PADDR-1:0]     addr_b,
    output logic [FCW_WIDTH-1:0] data_b
);

    logic [FCW_WIDTH-1:0] mem [NUM_PROFILES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PROFILES; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign data_a = mem[addr_a];
    assign data_b = mem[addr_b];

endmodule

// File: rtl/pll_profile_sequencer.sv
// SPI command decoder driving the DSM FCW from a bank of profiles,
// either statically or as a timed sweep with optional looping.
module pll_profile_sequencer
    import pll_pkg::*;
#(
    parameter int NUM_PROFILES = 4,
    parameter int FCW_WIDTH    = 43,
    parameter int DWELL_WIDTH  = 12,
    localparam int PADDR  = (NUM_PROFILES > 2) ? $clog2(NUM_PROFILES) : 1,
    localparam int NCHUNK = (FCW_WIDTH + CHUNK_W - 1) / CHUNK_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          cmd_data,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    output logic [15:0]          rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [FCW_WIDTH-1:0] fcw,
    output logic                 fcw_load,
    output logic                 dsm_enable,
    output logic [PADDR-1:0]     active_profile,
    output logic                 cmd_err
);

    localparam int PAD_W = NCHUNK * CHUNK_W;
    localparam logic [1:0] LAST_CHUNK = 2'(NCHUNK - 1);
    localparam logic [PADDR-1:0] MAX_PROF = PADDR'(NUM_PROFILES - 1);
    localparam logic [PADDR-1:0] P_ONE = PADDR'(1);
    localparam logic [DWELL_WIDTH-1:0] D_ONE = DWELL_WIDTH'(1);

    logic [1:0] op, sub;
    logic [CHUNK_W-1:0] payload;

    state_t state, state_n, ret, ret_n;
    logic [CHUNK_W-1:0] staging [NCHUNK];
    logic [CHUNK_W-1:0] staging_n [NCHUNK];
    logic [NCHUNK-1:0] mask, mask_n;
    logic [PADDR-1:0] ptr, ptr_n, seq_last, last_n, active_n;
    logic [DWELL_WIDTH-1:0] dwell, dwell_n, cnt, cnt_n;
    logic loop, loop_n;
    logic [1:0] rd_idx, rd_idx_n;
    logic [FCW_WIDTH-1:0] fcw_n;
    logic load_n, en_n, err_n;

    logic accept, sweeping, expire, we;
    logic [PAD_W-1:0] staged, rd_word;
    logic [FCW_WIDTH-1:0] wdata, data_a, data_b;
    logic [PADDR-1:0] addr_a, step_to;

    assign op      = cmd_data[15:14];
    assign sub     = cmd_data[13:12];
    assign payload = cmd_data[11:0];

    assign cmd_ready = (state != ST_READOUT);
    assign rd_valid  = (state == ST_READOUT);
    assign accept    = cmd_valid && cmd_ready;
    assign sweeping  = (state == ST_SWEEP) ||
                       (state == ST_READOUT && ret == ST_SWEEP);
    // dwell of 0 expires every clock, same as dwell of 1
    assign expire  = (dwell == '0) || (cnt == dwell - D_ONE);
    assign step_to = (active_profile >= seq_last) ? '0
                   : active_profile + P_ONE;
    assign addr_a  = (accept && op == OP_SEQ) ? '0 : step_to;

    assign rd_word = PAD_W'(data_b);
    assign rd_data = rd_valid
                   ? {2'b10, rd_idx, rd_word[rd_idx*CHUNK_W +: CHUNK_W]}
                   : '0;

    always_comb begin
        staged = '0;
        for (int i = 0; i < NCHUNK - 1; i++)
            staged[i*CHUNK_W +: CHUNK_W] = staging[i];
        staged[(NCHUNK-1)*CHUNK_W +: CHUNK_W] = payload;
    end
    assign wdata = FCW_WIDTH'(staged);

    pll_profile_bank #(
        .NUM_PROFILES(NUM_PROFILES),
        .FCW_WIDTH   (FCW_WIDTH),
        .PADDR       (PADDR)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (ptr),
        .wdata (wdata),
        .addr_a(addr_a),
        .data_a(data_a),
        .addr_b(ptr),
        .data_b(data_b)
    );

    always_comb begin
        state_n   = state;
        ret_n     = ret;
        staging_n = staging;
        mask_n    = mask;
        ptr_n     = ptr;
        last_n    = seq_last;
        dwell_n   = dwell;
        loop_n    = loop;
        cnt_n     = cnt;
        rd_idx_n  = rd_idx;
        active_n  = active_profile;
        fcw_n     = fcw;
        load_n    = 1'b0;
        en_n      = dsm_enable;
        err_n     = 1'b0;
        we        = 1'b0;

        // an accepted command pre-empts the step on an expiry cycle
        if (sweeping) begin
            if (expire) begin
                cnt_n = '0;
                if (!accept) begin
                    if (active_profile >= seq_last && !loop) begin
                        if (state == ST_READOUT) ret_n = ST_STATIC;
                        else state_n = ST_STATIC;
                    end else begin
                        active_n = step_to;
                        fcw_n    = data_a;
                        load_n   = 1'b1;
                    end
                end
            end else begin
                cnt_n = cnt + D_ONE;
            end
        end

        if (state == ST_READOUT && rd_ready) begin
            if (rd_idx == LAST_CHUNK) begin
                rd_idx_n = '0;
                state_n  = ret_n;
            end else begin
                rd_idx_n = rd_idx + 2'd1;
            end
        end

        if (accept) begin
            unique case (op)
                OP_SEQ: begin
                    dwell_n  = DWELL_WIDTH'(payload);
                    loop_n   = sub[0];
                    state_n  = ST_SWEEP;
                    active_n = '0;
                    fcw_n    = data_a;
                    load_n   = 1'b1;
                    en_n     = 1'b1;
                    cnt_n    = '0;
                end
                OP_WRITE: begin
                    if (int'(sub) >= NCHUNK) begin
                        err_n = 1'b1;
                    end else if (sub == LAST_CHUNK) begin
                        mask_n = '0;
                        if (&mask[NCHUNK-2:0]) begin
                            we = 1'b1;
                            if (dsm_enable && ptr == active_profile) begin
                                fcw_n  = wdata;
                                load_n = 1'b1;
                            end
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        staging_n[sub] = payload;
                        mask_n[sub]    = 1'b1;
                    end
                end
                OP_READ: begin
                    ret_n    = state;
                    state_n  = ST_READOUT;
                    rd_idx_n = '0;
                end
                OP_CTRL: begin
                    unique case (sub)
                        CTRL_SELECT: begin
                            if (int'(payload) >= NUM_PROFILES) err_n = 1'b1;
                            else ptr_n = payload[PADDR-1:0];
                        end
                        CTRL_SET_LAST: begin
                            if (int'(payload) >= NUM_PROFILES - 1)
                                last_n = MAX_PROF;
                            else
                                last_n = payload[PADDR-1:0];
                        end
                        CTRL_STOP: begin
                            state_n = ST_IDLE;
                            en_n    = 1'b0;
                        end
                        CTRL_STATIC: begin
                            state_n  = ST_STATIC;
                            active_n = ptr;
                            fcw_n    = data_b;
                            load_n   = 1'b1;
                            en_n     = 1'b1;
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            ret            <= ST_IDLE;
            for (int i = 0; i < NCHUNK; i++) staging[i] <= '0;
            mask           <= '0;
            ptr            <= '0;
            seq_last       <= '0;
            dwell          <= '0;
            loop           <= 1'b0;
            cnt            <= '0;
            rd_idx         <= '0;
            active_profile <= '0;
            fcw            <= '0;
            fcw_load       <= 1'b0;
            dsm_enable     <= 1'b0;
            cmd_err        <= 1'b0;
        end else begin
            state          <= state_n;
            ret            <= ret_n;
            staging        <= staging_n;
            mask           <= mask_n;
            ptr            <= ptr_n;
            seq_last       <= last_n;
            dwell          <= dwell_n;
            loop           <= loop_n;
            cnt            <= cnt_n;
            rd_idx         <= rd_idx_n;
            active_profile <= active_n;
            fcw            <= fcw_n;
            fcw_load       <= load_n;
            dsm_enable     <= en_n;
            cmd_err        <= err_n;
        end
    end

endmodule
